// File: rtl/random_range_gen.sv
// Free-running Galois LFSR with a request/ack draw engine that returns values uniform in [0, RANGE-1].
// Rejection sampling retries up to MAX_TRIES times, then folds the candidate back into range.
module random_range_gen #(
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] TAPS      = 32'h80200003,
    parameter logic [LFSR_W-1:0] SEED      = 32'hACE12024,
    parameter int                RANGE     = 24,
    parameter int                OUT_W     = 8,
    parameter int                MAX_TRIES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              req,
    output logic              ready,
    output logic              rnd_valid,
    output logic [OUT_W-1:0]  rnd_out,
    input  logic              rnd_ack,
    output logic [LFSR_W-1:0] lfsr_state
);

    localparam int         K       = (RANGE > 1) ? $clog2(RANGE) : 1;
    localparam int         KP1     = K + 1;
    localparam logic [K:0] RANGE_K = KP1'(RANGE);
    localparam logic [3:0] MAX_T   = 4'(MAX_TRIES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          tries, tries_nxt;
    logic [LFSR_W-1:0]   lfsr, lfsr_nxt;
    logic [OUT_W-1:0]    rnd_out_nxt;
    logic                rnd_valid_nxt;
    logic [K-1:0]        cand;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    // A rejected candidate lies in [RANGE, 2^K) and 2^K < 2*RANGE, so one subtraction lands in range.
    function automatic logic [OUT_W-1:0] fold(input logic [K-1:0] c);
        logic [K:0] diff;
        diff = {1'b0, c} - RANGE_K;
        return OUT_W'(diff[K-1:0]);
    endfunction

    assign cand       = lfsr[K-1:0];
    assign ready      = (state == IDLE);
    assign lfsr_state = lfsr;

    always_comb begin
        if (seed_load) begin
            lfsr_nxt = (seed_in == '0) ? SEED : seed_in;
        end else begin
            lfsr_nxt = lfsr_step(lfsr);
        end
    end

    always_comb begin
        state_nxt     = state;
        tries_nxt     = tries;
        rnd_out_nxt   = rnd_out;
        rnd_valid_nxt = rnd_valid;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = DRAW;
                    tries_nxt = 4'd0;
                end
            end
            DRAW: begin
                if ({1'b0, cand} < RANGE_K) begin
                    rnd_out_nxt   = OUT_W'(cand);
                    rnd_valid_nxt = 1'b1;
                    state_nxt     = HOLD;
                end else if (tries < MAX_T) begin
                    tries_nxt = tries + 4'd1;
                end else begin
                    rnd_out_nxt   = fold(cand);
                    rnd_valid_nxt = 1'b1;
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                if (rnd_ack) begin
                    rnd_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt     = IDLE;
                rnd_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr      <= SEED;
            state     <= IDLE;
            tries     <= 4'd0;
            rnd_valid <= 1'b0;
            rnd_out   <= '0;
        end else begin
            lfsr      <= lfsr_nxt;
            state     <= state_nxt;
            tries     <= tries_nxt;
            rnd_valid <= rnd_valid_nxt;
            rnd_out   <= rnd_out_nxt;
        end
    end

endmodule

// File: tb/tb_random_range_gen.sv
// Scoreboard bench for random_range_gen: directed draws push expected values, monitors pop on each new rnd_valid.
// A second instance (RANGE=17, MAX_TRIES=0) covers the immediate-fallback case.
module tb_random_range_gen;

    logic        clk;
    logic        reset;

    logic        seed_load, req, rnd_ack, ready, rnd_valid;
    logic [31:0] seed_in, lfsr_state;
    logic [7:0]  rnd_out;

    logic        seed_load_b, req_b, rnd_ack_b, ready_b, rnd_valid_b;
    logic [31:0] seed_in_b, lfsr_state_b;
    logic [7:0]  rnd_out_b;

    int n_pass  = 0;
    int n_total = 0;

    int q_a[$];
    int q_b[$];
    logic was_a = 1'b0;
    logic was_b = 1'b0;

    bit soak_on = 1'b0;
    int soak_draws = 0;
    int soak_bad = 0;
    int hist[24];

    random_range_gen u_dut (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .ready(ready), .rnd_valid(rnd_valid), .rnd_out(rnd_out),
        .rnd_ack(rnd_ack), .lfsr_state(lfsr_state)
    );

    random_range_gen #(.RANGE(17), .MAX_TRIES(0)) u_fb (
        .clk(clk), .reset(reset), .seed_load(seed_load_b), .seed_in(seed_in_b),
        .req(req_b), .ready(ready_b), .rnd_valid(rnd_valid_b), .rnd_out(rnd_out_b),
        .rnd_ack(rnd_ack_b), .lfsr_state(lfsr_state_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    endfunction

    // Monitors: each rising rnd_valid consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rnd_valid && !was_a) begin
            if (soak_on) begin
                soak_draws++;
                if (rnd_out < 8'd24) hist[rnd_out]++;
                else soak_bad++;
            end else if (q_a.size() > 0) begin
                check("draw_a", 64'(rnd_out), 64'(q_a.pop_front()));
            end else begin
                n_total++;
                $display("FAIL unexpected_draw_a: got %0d required no draw", rnd_out);
            end
        end
        was_a = rnd_valid;
    end

    always @(negedge clk) begin
        if (rnd_valid_b && !was_b) begin
            if (q_b.size() > 0) begin
                check("draw_b", 64'(rnd_out_b), 64'(q_b.pop_front()));
            end else begin
                n_total++;
                $display("FAIL unexpected_draw_b: got %0d required no draw", rnd_out_b);
            end
        end
        was_b = rnd_valid_b;
    end

    initial begin
        int seeds[5];
        logic [31:0] model;
        int lfsr_errs;
        int cyc;

        seed_load = 0; seed_in = 0; req = 0; rnd_ack = 0;
        seed_load_b = 0; seed_in_b = 0; req_b = 0; rnd_ack_b = 0;
        foreach (hist[i]) hist[i] = 0;

        // Asynchronous reset before any clock edge
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_lfsr", lfsr_state, 32'hACE12024);
        check("rst_ready", ready, 1'b1);
        check("rst_valid", rnd_valid, 1'b0);
        check("rst_out", rnd_out, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_lfsr", lfsr_state, 32'hACE12024);
        tick();
        check("first_step", lfsr_state, 32'h56709012);

        // Seed sequence from 1
        seed_load = 1; seed_in = 32'h1;
        tick();
        seed_load = 0;
        check("seed1_0", lfsr_state, 32'h00000001);
        tick(); check("seed1_1", lfsr_state, 32'h80200003);
        tick(); check("seed1_2", lfsr_state, 32'hC0300002);
        tick(); check("seed1_3", lfsr_state, 32'h60180001);

        // Zero seed falls back to SEED
        seed_load = 1; seed_in = 32'h0;
        tick();
        seed_load = 0;
        check("zero_seed", lfsr_state, 32'hACE12024);

        // Reject 27, then accept 9 loaded during DRAW
        seed_load = 1; seed_in = 32'h1B; req = 1; q_a.push_back(9);
        tick();
        check("ar_ready0", ready, 1'b0);
        check("ar_valid0", rnd_valid, 1'b0);
        check("ar_lfsr0", lfsr_state, 32'h1B);
        seed_in = 32'h9; req = 0;
        tick();
        check("ar_valid1", rnd_valid, 1'b0);
        check("ar_lfsr1", lfsr_state, 32'h9);
        seed_load = 0;
        tick();
        check("ar_valid2", rnd_valid, 1'b1);
        check("ar_out2", rnd_out, 8'd9);

        // Consumer stalls; a req pulse in HOLD must be dropped
        for (int i = 0; i < 10; i++) begin
            req = (i == 4);
            tick();
            check("hs_valid", rnd_valid, 1'b1);
            check("hs_out", rnd_out, 8'd9);
            check("hs_ready", ready, 1'b0);
        end
        req = 0;
        rnd_ack = 1;
        tick();
        rnd_ack = 0;
        check("ack_ready", ready, 1'b1);
        check("ack_valid", rnd_valid, 1'b0);
        check("ack_out_kept", rnd_out, 8'd9);
        tick();
        check("req_not_queued", ready, 1'b1);

        // Five rejections exhaust MAX_TRIES=4; fifth candidate 28 folds to 4
        seeds = '{30, 25, 26, 27, 28};
        seed_load = 1; seed_in = 32'(seeds[0]); req = 1; q_a.push_back(4);
        tick();
        req = 0;
        for (int i = 1; i < 5; i++) begin
            seed_in = 32'(seeds[i]);
            tick();
            check("retry_valid", rnd_valid, 1'b0);
        end
        seed_load = 0;
        tick();
        check("fold_valid", rnd_valid, 1'b1);
        check("fold_out", rnd_out, 8'd4);
        rnd_ack = 1;
        tick();
        rnd_ack = 0;

        // RANGE=17, MAX_TRIES=0: cand 20 -> 3 without retry
        seed_load_b = 1; seed_in_b = 32'h14; req_b = 1; q_b.push_back(3);
        tick();
        seed_load_b = 0; req_b = 0;
        check("fb_ready0", ready_b, 1'b0);
        tick();
        check("fb_valid", rnd_valid_b, 1'b1);
        check("fb_out", rnd_out_b, 8'd3);
        rnd_ack_b = 1;
        tick();
        rnd_ack_b = 0;
        check("fb_ready_back", ready_b, 1'b1);

        // Reset between edges while holding a value
        seed_load = 1; seed_in = 32'h5; req = 1; q_a.push_back(5);
        tick();
        seed_load = 0; req = 0;
        tick();
        check("hold_valid", rnd_valid, 1'b1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_valid", rnd_valid, 1'b0);
        check("mid_rst_out", rnd_out, 8'h00);
        check("mid_rst_ready", ready, 1'b1);
        check("mid_rst_lfsr", lfsr_state, 32'hACE12024);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rerelease_step", lfsr_state, 32'h56709012);

        // Soak with free-running req/ack and an independent LFSR model
        soak_on = 1;
        seed_load = 1; seed_in = 32'h12345678; req = 1; rnd_ack = 1;
        tick();
        seed_load = 0;
        model = 32'h12345678;
        lfsr_errs = (lfsr_state !== model) ? 1 : 0;
        cyc = 0;
        while (soak_draws < 10000 && cyc < 60000) begin
            tick();
            model = step(model);
            if (lfsr_state !== model) lfsr_errs++;
            cyc++;
        end
        req = 0;
        repeat (10) tick();
        rnd_ack = 0;
        soak_on = 0;
        check("soak_done", soak_draws >= 10000, 1'b1);
        check("soak_range", soak_bad, 0);
        check("soak_lfsr_model", lfsr_errs, 0);
        for (int v = 0; v < 24; v++) begin
            if (hist[v] * 10 < 3333 || hist[v] * 10 > 5000)
                $display("note: value %0d drawn %0d times, outside +/-20%% of 416.7", v, hist[v]);
        end

        check("sb_a_drained", q_a.size(), 0);
        check("sb_b_drained", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
